// File: rtl/elevator_pkg.sv
// Shared types, constants and small decode helpers for the 3-floor elevator car controller.
package elevator_pkg;

    localparam int NUM_FLOORS = 3;

    typedef logic [1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } car_state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;
    localparam logic [6:0] SEG_DIGIT_2 = 7'b0100100;
    localparam logic [6:0] SEG_DIGIT_3 = 7'b0110000;

    function automatic logic [NUM_FLOORS-1:0] floor_bit(input floor_t f);
        return NUM_FLOORS'(3'b001 << f);
    endfunction

    function automatic logic [NUM_FLOORS-1:0] above_mask(input floor_t f);
        case (f)
            2'd0:    return 3'b110;
            2'd1:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input floor_t f);
        case (f)
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [6:0] seg_digit(input floor_t f);
        case (f)
            2'd0:    return SEG_DIGIT_1;
            2'd1:    return SEG_DIGIT_2;
            default: return SEG_DIGIT_3;
        endcase
    endfunction

endpackage

// File: rtl/elevator_car_ctrl_door_timer.sv
// Door hold timer: loads DOOR_TIME, reloads while held (overload), stands still while frozen (sos).
module door_timer #(
    parameter int DOOR_TIME = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic hold,
    input  logic freeze,
    output logic expired
);

    localparam int TW = $clog2(DOOR_TIME + 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load || hold) begin
            r_cnt <= TW'(DOOR_TIME);
        end else if (!freeze && r_cnt != '0) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    // r_cnt is the number of open cycles still to run, the current one included
    assign expired = (r_cnt <= TW'(1));

endmodule

// File: rtl/elevator_car_ctrl.sv
// 3-floor car controller: call latching, step-counted position, SCAN direction and door timing.
// Defining ELEVATOR_FLOOR_7SEG_EN adds the registered active-low floor display output seg_n.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int STEPS_PER_FLOOR = 4,
    parameter int DOOR_TIME       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_clk,
    input  logic [2:0] call,
    input  logic       sos_mode,
    input  logic       weight_limit_exceeded,
    output logic       move_handler,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic [1:0] floor,
    output logic       dir_up,
    output logic       door_open,
    output logic [2:0] pending
`ifdef ELEVATOR_FLOOR_7SEG_EN
    ,
    output logic [6:0] seg_n
`endif
);

    localparam int PW = $clog2(STEPS_PER_FLOOR);

    car_state_t            r_state, w_state_nx;
    floor_t                r_floor, w_floor_nx, w_floor_adj;
    logic [PW-1:0]         r_pos, w_pos_nx;
    logic [NUM_FLOORS-1:0] r_pending, w_pend_all, w_pend_nx, w_beyond;
    logic                  r_dir_up, w_dir_nx;
    logic                  r_move_clk_q, r_step;
    logic                  w_at_last, w_door_load, w_door_expired;

    assign w_pend_all  = r_pending | call;
    assign w_at_last   = (r_pos == PW'(STEPS_PER_FLOOR - 1));
    assign w_floor_adj = r_dir_up ? floor_t'(r_floor + 2'd1) : floor_t'(r_floor - 2'd1);
    assign w_beyond    = r_dir_up ? above_mask(w_floor_adj) : below_mask(w_floor_adj);

    always_comb begin
        w_state_nx  = r_state;
        w_floor_nx  = r_floor;
        w_pos_nx    = r_pos;
        w_dir_nx    = r_dir_up;
        w_pend_nx   = w_pend_all;
        w_door_load = 1'b0;
        case (r_state)
            IDLE: begin
                w_pend_nx = w_pend_all & ~floor_bit(r_floor);
                if (|(w_pend_all & floor_bit(r_floor))) begin
                    w_state_nx  = DOOR_OPEN;
                    w_door_load = 1'b1;
                end else if (|w_pend_all) begin
                    w_state_nx = MOVING;
                    if (r_dir_up && |(w_pend_all & above_mask(r_floor))) begin
                        w_dir_nx = 1'b1;
                    end else if (|(w_pend_all & below_mask(r_floor))) begin
                        w_dir_nx = 1'b0;
                    end else begin
                        w_dir_nx = 1'b1;
                    end
                end
            end
            MOVING: begin
                if (r_step && !sos_mode) begin
                    if (w_at_last) begin
                        w_pos_nx   = '0;
                        w_floor_nx = w_floor_adj;
                        if (|(w_pend_all & floor_bit(w_floor_adj))) begin
                            w_state_nx  = DOOR_OPEN;
                            w_door_load = 1'b1;
                            w_pend_nx   = w_pend_all & ~floor_bit(w_floor_adj);
                        end else if (!(|(w_pend_all & w_beyond))) begin
                            w_state_nx = IDLE;
                        end
                    end else begin
                        w_pos_nx = r_pos + PW'(1);
                    end
                end
            end
            DOOR_OPEN: begin
                // A call for this floor is absorbed and simply keeps the door open longer
                w_pend_nx   = w_pend_all & ~floor_bit(r_floor);
                w_door_load = |(call & floor_bit(r_floor));
                if (w_door_expired && !w_door_load && !weight_limit_exceeded && !sos_mode) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_floor      <= '0;
            r_pos        <= '0;
            r_pending    <= '0;
            r_dir_up     <= 1'b1;
            r_move_clk_q <= 1'b0;
            r_step       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_floor      <= w_floor_nx;
            r_pos        <= w_pos_nx;
            r_pending    <= w_pend_nx;
            r_dir_up     <= w_dir_nx;
            r_move_clk_q <= move_clk;
            r_step       <= move_clk & ~r_move_clk_q;
        end
    end

    door_timer #(
        .DOOR_TIME(DOOR_TIME)
    ) u_door_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_door_load),
        .hold   (weight_limit_exceeded),
        .freeze (sos_mode),
        .expired(w_door_expired)
    );

    assign move_handler = (r_state == MOVING);
    assign door_open    = (r_state == DOOR_OPEN);
    assign floor        = r_floor;
    assign dir_up       = r_dir_up;
    assign pending      = r_pending;
    assign led1         = (r_floor == 2'd0) && (r_pos == '0);
    assign led2         = (r_floor == 2'd1) && (r_pos == '0);
    assign led3         = (r_floor == 2'd2) && (r_pos == '0);

`ifdef ELEVATOR_FLOOR_7SEG_EN
    logic [6:0] r_seg_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_n <= SEG_DIGIT_1;
        end else begin
            r_seg_n <= seg_digit(w_floor_nx);
        end
    end

    assign seg_n = r_seg_n;
`endif

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: directed scenarios followed by random call sets scored against a SCAN model.
module tb_elevator_car_ctrl;

    logic       clk;
    logic       rst;
    logic       move_clk;
    logic [2:0] call;
    logic       sos_mode;
    logic       weight_limit_exceeded;
    logic       move_handler;
    logic       led1, led2, led3;
    logic [1:0] floor;
    logic       dir_up;
    logic       door_open;
    logic [2:0] pending;
`ifdef ELEVATOR_FLOOR_7SEG_EN
    logic [6:0] seg_n;
`endif

    logic d_sos, d_weight, n_sos, n_weight;
    logic auto_en, noise_en, sb_en;
    int   pulses_req, pulses_done, ph;
    int   total, bad;
    int   m_floor;
    logic m_dir;
    logic [2:0] leds;

    typedef struct {
        int         fl;
        logic [2:0] pend;
        logic       dir;
    } exp_t;
    exp_t sb_q[$];

    assign sos_mode              = d_sos | n_sos;
    assign weight_limit_exceeded = d_weight | n_weight;
    assign leds                  = {led3, led2, led1};

    elevator_car_ctrl #(
        .STEPS_PER_FLOOR(4),
        .DOOR_TIME      (20)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .move_clk             (move_clk),
        .call                 (call),
        .sos_mode             (sos_mode),
        .weight_limit_exceeded(weight_limit_exceeded),
        .move_handler         (move_handler),
        .led1                 (led1),
        .led2                 (led2),
        .led3                 (led3),
        .floor                (floor),
        .dir_up               (dir_up),
        .door_open            (door_open),
        .pending              (pending)
`ifdef ELEVATOR_FLOOR_7SEG_EN
        ,
        .seg_n                (seg_n)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_exp(input int fl);
        case (fl)
            0:       return 7'b1111001;
            1:       return 7'b0100100;
            default: return 7'b0110000;
        endcase
    endfunction

    // move_clk source: free-running when auto_en, otherwise emits requested single pulses
    initial begin
        move_clk    = 1'b0;
        pulses_done = 0;
        ph          = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ph != 0 || auto_en || pulses_done != pulses_req) begin
                if (ph == 0) move_clk = 1'b1;
                if (ph == 2) move_clk = 1'b0;
                if (ph == 3) begin
                    ph = 0;
                    if (!auto_en) pulses_done++;
                end else begin
                    ph++;
                end
            end
        end
    end

    initial begin
        n_sos    = 1'b0;
        n_weight = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (noise_en) begin
                if ($urandom_range(0, 15) == 0) n_sos = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 11) == 0) n_weight = ($urandom_range(0, 2) == 0);
            end else begin
                n_sos    = 1'b0;
                n_weight = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every door opening must match the next expected stop
    initial begin
        logic prev_door;
        exp_t e;
        prev_door = 1'b0;
        forever begin
            @(negedge clk);
            if (sb_en && door_open && !prev_door) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rand_unexpected_stop: got door open at floor %0d, required no stop", floor);
                end else begin
                    e = sb_q.pop_front();
                    chk("rand_stop_floor", floor, e.fl);
                    chk("rand_stop_pending", pending, e.pend);
                    chk("rand_stop_dir", dir_up, e.dir);
                    chk("rand_stop_led", leds[e.fl], 1);
`ifdef ELEVATOR_FLOOR_7SEG_EN
                    chk("rand_stop_seg", seg_n, seg_exp(e.fl));
`endif
                end
            end
            prev_door = door_open;
        end
    end

    // SCAN reference: serve the current floor, then sweep in the held direction, reversing only when nothing lies ahead
    task automatic model_push(input logic [2:0] mask);
        logic [2:0] p;
        bit         up_any, dn_any;
        int         s, c;
        exp_t       e;
        p = mask;
        if (p[m_floor]) begin
            p[m_floor] = 1'b0;
            e.fl = m_floor; e.pend = p; e.dir = m_dir;
            sb_q.push_back(e);
        end
        while (p != 3'b000) begin
            up_any = 0;
            dn_any = 0;
            for (int i = 0; i < 3; i++) begin
                if (p[i] && i > m_floor) up_any = 1;
                if (p[i] && i < m_floor) dn_any = 1;
            end
            if (m_dir && up_any) m_dir = 1'b1;
            else if (dn_any) m_dir = 1'b0;
            else m_dir = 1'b1;
            s = -1;
            for (int k = 1; k < 3; k++) begin
                c = m_dir ? m_floor + k : m_floor - k;
                if (s < 0 && c >= 0 && c < 3) begin
                    if (p[c]) s = c;
                end
            end
            if (s < 0) break;
            p[s]    = 1'b0;
            m_floor = s;
            e.fl = s; e.pend = p; e.dir = m_dir;
            sb_q.push_back(e);
        end
    endtask

    task automatic pulses(input int n);
        int guard;
        guard = 0;
        pulses_req += n;
        while (pulses_done != pulses_req && guard < 50 * n) begin
            @(negedge clk);
            guard++;
        end
        if (pulses_done != pulses_req) begin
            total++;
            bad++;
            $display("FAIL pulse_timeout: got %0d pulses required %0d", pulses_done, pulses_req);
        end
    endtask

    task automatic call_pulse(input logic [2:0] mask);
        @(posedge clk);
        #1 call = mask;
        @(posedge clk);
        #1 call = 3'b000;
    endtask

    task automatic wait_door_closed();
        int g;
        g = 0;
        while (door_open && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (door_open) begin
            total++;
            bad++;
            $display("FAIL door_close_timeout: got door_open=1 required 0");
        end
    endtask

    task automatic wait_quiet(input int limit);
        int g;
        g = 0;
        while ((door_open || move_handler || pending != 3'b000) && g < limit) begin
            @(negedge clk);
            g++;
        end
        if (door_open || move_handler || pending != 3'b000) begin
            total++;
            bad++;
            $display("FAIL quiet_timeout: got door=%0d move=%0d pending=%0d required all 0",
                     door_open, move_handler, pending);
        end
    endtask

    initial begin
        int n;
        logic [2:0] mask;
        total = 0; bad = 0;
        rst = 1'b1; call = 3'b000; d_sos = 1'b0; d_weight = 1'b0;
        auto_en = 1'b0; noise_en = 1'b0; sb_en = 1'b0; pulses_req = 0;
        m_floor = 0; m_dir = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        chk("reset_floor", floor, 0);
        chk("reset_leds", leds, 3'b001);
        chk("reset_move", move_handler, 0);
        chk("reset_door", door_open, 0);
        chk("reset_pending", pending, 0);
        chk("reset_dir", dir_up, 1);
`ifdef ELEVATOR_FLOOR_7SEG_EN
        chk("reset_seg", seg_n, 7'b1111001);
`endif

        // Two-floor trip up, passing floor 1
        call_pulse(3'b100);
        @(negedge clk);
        chk("trip_move_next_cycle", move_handler, 1);
        chk("trip_pending_latched", pending, 3'b100);
        pulses(4);
        chk("trip_mid_floor", floor, 1);
        chk("trip_mid_led2", led2, 1);
        chk("trip_mid_moving", move_handler, 1);
        pulses(4);
        chk("trip_end_floor", floor, 2);
        chk("trip_end_led3", led3, 1);
        chk("trip_end_move", move_handler, 0);
        chk("trip_end_door", door_open, 1);
        chk("trip_end_pending", pending, 0);
        wait_door_closed();

        // Door duration, then duration with an overload in the middle
        call_pulse(3'b100);
        @(negedge clk);
        chk("door_same_floor_pending", pending, 0);
        n = 0;
        while (door_open && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("door_open_cycles", n, 20);
        call_pulse(3'b100);
        repeat (5) @(posedge clk);
        #1 d_weight = 1'b1;
        repeat (10) @(posedge clk);
        #1 d_weight = 1'b0;
        @(negedge clk);
        n = 0;
        while (door_open && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("door_after_weight_cycles", n, 20);

        // Emergency hold while travelling down from floor 2
        call_pulse(3'b001);
        @(negedge clk);
        chk("sos_dir_down", dir_up, 0);
        pulses(2);
        d_sos = 1'b1;
        pulses(5);
        chk("sos_floor_held", floor, 2);
        chk("sos_leds_held", leds, 3'b000);
        chk("sos_still_moving", move_handler, 1);
        d_sos = 1'b0;
        pulses(1);
        chk("sos_resume_3_floor", floor, 2);
        chk("sos_resume_3_led2", led2, 0);
        pulses(1);
        chk("sos_resume_4_floor", floor, 1);
        chk("sos_resume_4_led2", led2, 1);
        pulses(4);
        chk("sos_arrive_floor", floor, 0);
        chk("sos_arrive_door", door_open, 1);
        wait_door_closed();

        // Go to floor 1 heading up, then request 0 and 2 together
        call_pulse(3'b010);
        @(negedge clk);
        chk("rev_turn_up", dir_up, 1);
        pulses(4);
        chk("rev_at1_floor", floor, 1);
        chk("rev_at1_door", door_open, 1);
        wait_door_closed();
        call_pulse(3'b101);
        @(negedge clk);
        chk("rev_keep_up", dir_up, 1);
        chk("rev_pending", pending, 3'b101);
        pulses(4);
        chk("rev_first_floor", floor, 2);
        chk("rev_first_door", door_open, 1);
        chk("rev_first_pending", pending, 3'b001);
        wait_door_closed();
        @(negedge clk);
        chk("rev_reversed_dir", dir_up, 0);
        chk("rev_reversed_moving", move_handler, 1);
        pulses(8);
        chk("rev_second_floor", floor, 0);
        chk("rev_second_door", door_open, 1);
        chk("rev_second_pending", pending, 0);
        wait_door_closed();

        // Call for floor 1 lands on the very cycle the car arrives there
        call_pulse(3'b100);
        pulses(3);
        pulses_req += 1;
        @(posedge clk);
        @(posedge clk);
        #1 call = 3'b010;
        @(posedge clk);
        #1 call = 3'b000;
        n = 0;
        while (pulses_done != pulses_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("pass_stop_floor", floor, 1);
        chk("pass_stop_door", door_open, 1);
        chk("pass_stop_pending", pending, 3'b100);

        // Random call sets with random sos/overload noise
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        m_floor = 0;
        m_dir   = 1'b1;
        auto_en  = 1'b1;
        noise_en = 1'b1;
        sb_en    = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 25; t++) begin
            wait_quiet(8000);
            chk("rand_rest_floor", floor, m_floor);
            mask = 3'($urandom_range(1, 7));
            model_push(mask);
            call_pulse(mask);
        end
        wait_quiet(8000);
        chk("rand_final_floor", floor, m_floor);
        chk("rand_queue_drained", sb_q.size(), 0);
        noise_en = 1'b0;
        auto_en  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
- Car controller directly downstream of the move-clock generator.
- Latches floor calls for a 3-floor car and counts rising edges of move_clk as travel steps to track car position.
- Drives move_handler and the per-floor indicators led1..led3, both of which feed back into the move-clock generator.
- Runs door timing and SCAN-style direction selection.

Parameters:
- STEPS_PER_FLOOR, 4, move_clk rising edges per floor of travel; minimum 2.
- DOOR_TIME, 20, clk cycles the door stays open.

Ports:
- clk  in  1  system clock
- rst  in  1  reset (synchronous, active-high)
- move_clk  in  1  step strobe from the move-clock generator; level signal, rising edge counts
- call  in  3  call buttons; bit i = floor i+1; a 1-cycle pulse is sufficient
- sos_mode  in  1  emergency hold
- weight_limit_exceeded  in  1  overload
- move_handler  out  1  1 while state is MOVING
- led1, led2, led3  out  1 each  car aligned at floor 1/2/3 (floor==i and pos==0)
- floor  out  2  current floor index 0..2
- dir_up  out  1  current travel direction
- door_open  out  1  1 in DOOR_OPEN
- pending  out  3  latched requests

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, floor=0, pos=0, pending=0, dir_up=1, move_handler=0, door_open=0, led1=1, led2=0, led3=0, door timer=0, move_clk_q=0.
- Reset mid-travel returns the car to floor 0, pos 0; there is no position persistence.
- Step detection: move_clk_q<=move_clk each cycle; step = move_clk & ~move_clk_q. pos and floor update on the cycle after the edge is sampled.
- Request latch: pending |= call every cycle, in every state, including during sos.
  - A call for the current floor while in DOOR_OPEN or IDLE is not latched.
  - Such a call in DOOR_OPEN reloads the door timer.
  - In IDLE it causes a transition to DOOR_OPEN.
- States: IDLE, MOVING, DOOR_OPEN.
- IDLE:
  - pending==0 -> stay.
  - pending[floor] -> DOOR_OPEN.
  - Else: dir_up and any pending above -> dir_up=1, MOVING.
  - Else any pending below -> dir_up=0, MOVING.
  - Else -> dir_up=1, MOVING.
- MOVING:
  - A step with sos_mode=0 advances pos. Steps while sos_mode=1 are ignored.
  - When pos would reach STEPS_PER_FLOOR: pos=0, floor+=dir (+1 up, -1 down).
  - On that arrival cycle:
    - pending[new floor] (including a call arriving the same cycle) -> DOOR_OPEN; clear that bit.
    - Else pending beyond new floor in dir -> stay MOVING.
    - Else -> IDLE.
  - floor never leaves 0..2: MOVING is never entered toward a wall.
- DOOR_OPEN:
  - Timer loads DOOR_TIME on entry and decrements each cycle.
  - Timer is reloaded while weight_limit_exceeded=1.
  - Timer is frozen while sos_mode=1.
  - When timer==0, weight_limit_exceeded=0 and sos_mode=0 -> IDLE.
  - pending[floor] is forced to 0 throughout.
- Latency:
  - Last step edge to move_handler=0 / door_open=1: 2 clk.
  - IDLE with a remote request to move_handler=1: 1 clk.
- Width rules: pos width is $clog2(STEPS_PER_FLOOR); timer width is $clog2(DOOR_TIME+1). All arithmetic is unsigned with no wrap reachable.

Optional Feature:
- Macro: ELEVATOR_FLOOR_7SEG_EN.
- When defined: adds output seg_n[6:0], active-low segments a..g, registered, showing digit floor+1. Reset value shows "1" (7'b1111001).
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package elevator_pkg: NUM_FLOORS=3, floor_t (2-bit), state enum car_state_t {IDLE, MOVING, DOOR_OPEN}, and the 7-segment digit constants.
- One natural sub-module: door_timer.
  - Inputs: load, hold (weight), freeze (sos).
  - Outputs: expired.
  - Parameterised by DOOR_TIME.

Test Plan:
1. Reset: assert rst 1 cycle -> floor=0, led1=1, led2=0, led3=0, move_handler=0, pending=0, dir_up=1; seg_n=7'b1111001 if ELEVATOR_FLOOR_7SEG_EN.
2. call=3'b100 pulse at floor 0, STEPS_PER_FLOOR=4 -> move_handler=1 next cycle.
   - Led2 high after 4 edges with move_handler still 1.
   - After 8 edges: floor=2, led3=1, move_handler=0, door_open=1, pending=0.
3. Door: DOOR_TIME=20 with no inputs -> door_open held exactly 20 cycles, then IDLE.
   - Weight asserted for 10 cycles mid-count -> close delayed to 20 cycles after deassert.
4. sos_mode=1 for 5 move_clk edges while MOVING -> pos and floor unchanged; travel resumes exactly when deasserted.
5. At floor 1 going up, call=3'b101 -> serves floor 2 first, then reverses (dir_up=0), then opens at floor 0.
6. Same-cycle call on the arrival floor while passing through -> stops, door opens, bit never left set.
